me_frame_sched: RTL and testbench
=================================

// Module: me_frame_sched
// PURPOSE
//   Frame-level scheduler for the motion estimation core. It walks every macroblock of a
//   frame in raster order and starts one search per macroblock over the core's req/ack
//   interface. It captures min_sad/min_mvec, emits one result per macroblock on a
//   valid/ready stream, and keeps a saturating frame SAD total.
// PARAMETERS
//   MB_COLS    4      macroblocks per row (>=2)
//   MB_ROWS    3      macroblock rows (>=2)
//   SAD_WIDTH  16     width of the core's SAD/threshold
//   CNT_WIDTH  12     width of the core's motion vector index
//   FSAD_WIDTH 24     frame SAD accumulator width (>=SAD_WIDTH)
//   TIMEOUT    8192   watchdog limit in cycles (used only with ME_FRAME_SCHED_TIMEOUT_EN)
// PORTS
//   clk          in   1             clock
//   rst          in   1             synchronous, active-high reset
//   start        in   1             start a frame (ignored unless IDLE)
//   threshold    in   SAD_WIDTH     early-stop threshold, latched at start
//   busy         out  1             high from accepted start until done
//   done         out  1             1-cycle pulse after last result accepted
//   frame_sad    out  FSAD_WIDTH    saturating sum of result SADs; held after done
//   me_req       out  1             request to core
//   me_threshold out  SAD_WIDTH     threshold to core (latched copy)
//   me_mb_x      out  clog2(MB_COLS)  current macroblock column (to frame addr base)
//   me_mb_y      out  clog2(MB_ROWS)  current macroblock row
//   me_ack       in   1             core completion
//   me_sad       in   SAD_WIDTH     core min_sad, valid when me_ack=1
//   me_mvec      in   CNT_WIDTH     core min_mvec, valid when me_ack=1
//   res_valid    out  1             result valid
//   res_ready    in   1             downstream ready
//   res_sad      out  SAD_WIDTH     result SAD
//   res_mvec     out  CNT_WIDTH     result vector index
//   res_mb_x/y   out  as me_mb_x/y  macroblock position of result
//   res_err      out  1             result produced by timeout (0 without macro)
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0 (busy, done, me_req, res_valid, frame_sad, mb_x/y,
//     res_*, me_threshold).
//   FSM: IDLE -> ISSUE -> WAIT -> PUSH -> (ISSUE | DONE) -> IDLE.
//   IDLE:  start=1 latches threshold, clears frame_sad and mb_x/y to 0, sets busy. Next: ISSUE.
//   ISSUE: me_req=1 for one cycle. Next: WAIT.
//   WAIT:  me_req stays 1 until me_ack is sampled high. On ack, capture sad/mvec/mb_x/y
//          into res_*, drop me_req in the same edge, set res_valid. Next: PUSH.
//          frame_sad += me_sad, saturating at all-ones.
//   PUSH:  me_req=0 (guarantees >=1 low cycle between requests). res_valid is held and
//          res_* are stable until res_ready=1. On the handshake:
//          - last MB (x=MB_COLS-1, y=MB_ROWS-1): go to DONE;
//          - otherwise x++, or x=0/y++ on row wrap, then go to ISSUE.
//          res_valid & res_ready in the same cycle ack arrives is impossible (1-cycle
//          latency min).
//   DONE:  done=1 for one cycle, busy=0. Next: IDLE. start in DONE is ignored.
//   start while busy: ignored, no effect on threshold or counters.
//   me_ack outside WAIT: ignored.
//   rst mid-frame: immediate return to IDLE with reset values. A partially pushed result
//     is dropped.
//   Minimum per-MB cost: ISSUE + WAIT(>=1) + PUSH(>=1) cycles.
// CONFIGURATION
//   ME_FRAME_SCHED_TIMEOUT_EN defined:
//   - WAIT cycle counter counts up; it is cleared on entry to ISSUE.
//   - When it reaches TIMEOUT with no ack: drop me_req, capture res_sad=all-ones,
//     res_mvec=0, res_err=1, go to PUSH.
//   - frame_sad saturates to all-ones.
//   - A late me_ack after the timeout is ignored.
//   Not defined: WAIT is unbounded; res_err tied 0; no counter logic.
// TESTING
//   1 reset then start, threshold=0x100; the core model acks each req after 5 cycles with
//     sad=10*n, res_ready=1 -> 12 results, (x,y) in raster order (0,0)..(3,2); done
//     pulses once; frame_sad=660.
//   2 res_ready held low 7 cycles on MB 1 -> res_valid and res_* stable; me_req stays 0;
//     MB 2 is not issued until the handshake.
//   3 start pulsed during WAIT of MB 3, and me_ack pulsed in IDLE -> no restart, no
//     spurious result, no counter change.
//   4 me_sad=0xFFFF on all MBs with FSAD_WIDTH=SAD_WIDTH -> frame_sad saturates at 0xFFFF,
//     no wrap.
//   5 rst asserted in PUSH of MB 5 -> next cycle: IDLE; busy, res_valid, me_req=0;
//     frame_sad=0. A new start resumes from (0,0).
//   6 (TIMEOUT_EN, TIMEOUT=16) core never acks MB 0 -> me_req drops after 16 WAIT
//     cycles; result sad=0xFFFF, err=1. A later ack is ignored and MB 1 proceeds normally.

Source files
------------

// File: rtl/me_frame_sched.sv
// -----------------------------------------------------------------------------
// me_frame_sched
//
// Frame-level scheduler for the motion estimation core. Walks every macroblock
// of a frame in raster order, starts one search per macroblock over the core's
// req/ack interface, forwards each min_sad/min_mvec as one result on a
// valid/ready stream, and keeps a saturating frame SAD total.
//
// Optional feature (compile-time macro):
//   ME_FRAME_SCHED_TIMEOUT_EN  - bounds the wait for me_ack with a watchdog of
//                                TIMEOUT cycles; a timed-out macroblock yields
//                                a result with res_sad = all-ones, res_mvec = 0
//                                and res_err = 1. Without the macro the wait is
//                                unbounded and res_err is tied low.
//
// Ports:
//   clk           clock
//   rst           synchronous, active-high reset
//   start         start a frame (only honoured in IDLE)
//   threshold     early-stop threshold, latched at start
//   busy          high from accepted start until the frame is done
//   done          one-cycle pulse after the last result is accepted
//   frame_sad     saturating sum of result SADs, held after done
//   me_req        request to the core (held until me_ack)
//   me_threshold  latched threshold presented to the core
//   me_mb_x/y     current macroblock column/row
//   me_ack        core completion strobe
//   me_sad        core min_sad, valid with me_ack
//   me_mvec       core min_mvec, valid with me_ack
//   res_valid     result valid
//   res_ready     downstream ready
//   res_sad       result SAD
//   res_mvec      result motion vector index
//   res_mb_x/y    macroblock position of the result
//   res_err       result produced by the watchdog
// -----------------------------------------------------------------------------
module me_frame_sched #(
    parameter int MB_COLS    = 4,
    parameter int MB_ROWS    = 3,
    parameter int SAD_WIDTH  = 16,
    parameter int CNT_WIDTH  = 12,
    parameter int FSAD_WIDTH = 24,
    parameter int TIMEOUT    = 8192
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [SAD_WIDTH-1:0]         threshold,
    output logic                         busy,
    output logic                         done,
    output logic [FSAD_WIDTH-1:0]        frame_sad,
    output logic                         me_req,
    output logic [SAD_WIDTH-1:0]         me_threshold,
    output logic [$clog2(MB_COLS)-1:0]   me_mb_x,
    output logic [$clog2(MB_ROWS)-1:0]   me_mb_y,
    input  logic                         me_ack,
    input  logic [SAD_WIDTH-1:0]         me_sad,
    input  logic [CNT_WIDTH-1:0]         me_mvec,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [SAD_WIDTH-1:0]         res_sad,
    output logic [CNT_WIDTH-1:0]         res_mvec,
    output logic [$clog2(MB_COLS)-1:0]   res_mb_x,
    output logic [$clog2(MB_ROWS)-1:0]   res_mb_y,
    output logic                         res_err
);

    localparam int XW    = $clog2(MB_COLS);
    localparam int YW    = $clog2(MB_ROWS);
    localparam int SUM_W = FSAD_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PUSH,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [SAD_WIDTH-1:0]   thr_q, thr_d;
    logic [XW-1:0]          x_q, x_d;
    logic [YW-1:0]          y_q, y_d;
    logic [FSAD_WIDTH-1:0]  fsad_q, fsad_d;
    logic [SAD_WIDTH-1:0]   res_sad_q, res_sad_d;
    logic [CNT_WIDTH-1:0]   res_mvec_q, res_mvec_d;
    logic [XW-1:0]          res_x_q, res_x_d;
    logic [YW-1:0]          res_y_q, res_y_d;

    // One extra bit catches the carry out of the frame total.
    logic [SUM_W-1:0]       sum_w;
    logic [FSAD_WIDTH-1:0]  fsad_sat;
    logic                   last_mb;

    assign sum_w    = {1'b0, fsad_q} + SUM_W'(me_sad);
    assign fsad_sat = sum_w[FSAD_WIDTH] ? {FSAD_WIDTH{1'b1}} : sum_w[FSAD_WIDTH-1:0];
    assign last_mb  = (x_q == XW'(MB_COLS - 1)) && (y_q == YW'(MB_ROWS - 1));

`ifdef ME_FRAME_SCHED_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [TW-1:0] wait_cnt_q, wait_cnt_d;
    logic          res_err_q, res_err_d;
    logic          timed_out;

    // Fires on the TIMEOUT-th cycle spent in WAIT.
    assign timed_out = (wait_cnt_q == TW'(TIMEOUT - 1));
`endif

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every variable gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        thr_d      = thr_q;
        x_d        = x_q;
        y_d        = y_q;
        fsad_d     = fsad_q;
        res_sad_d  = res_sad_q;
        res_mvec_d = res_mvec_q;
        res_x_d    = res_x_q;
        res_y_d    = res_y_q;
`ifdef ME_FRAME_SCHED_TIMEOUT_EN
        wait_cnt_d = wait_cnt_q;
        res_err_d  = res_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    thr_d   = threshold;
                    fsad_d  = '0;
                    x_d     = '0;
                    y_d     = '0;
                    state_d = S_ISSUE;
                end
            end

            S_ISSUE: begin
`ifdef ME_FRAME_SCHED_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end

            S_WAIT: begin
                // A real ack always wins over a watchdog expiry in the same cycle.
                if (me_ack) begin
                    res_sad_d  = me_sad;
                    res_mvec_d = me_mvec;
                    res_x_d    = x_q;
                    res_y_d    = y_q;
                    fsad_d     = fsad_sat;
`ifdef ME_FRAME_SCHED_TIMEOUT_EN
                    res_err_d  = 1'b0;
`endif
                    state_d    = S_PUSH;
                end
`ifdef ME_FRAME_SCHED_TIMEOUT_EN
                else if (timed_out) begin
                    res_sad_d  = {SAD_WIDTH{1'b1}};
                    res_mvec_d = '0;
                    res_x_d    = x_q;
                    res_y_d    = y_q;
                    fsad_d     = {FSAD_WIDTH{1'b1}};
                    res_err_d  = 1'b1;
                    state_d    = S_PUSH;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            S_PUSH: begin
                // Acks arriving here (including a late one after a timeout)
                // are not looked at: only WAIT samples me_ack.
                if (res_ready) begin
                    if (last_mb) begin
                        state_d = S_DONE;
                    end else begin
                        if (x_q == XW'(MB_COLS - 1)) begin
                            x_d = '0;
                            y_d = y_q + 1'b1;
                        end else begin
                            x_d = x_q + 1'b1;
                        end
                        state_d = S_ISSUE;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples the values
        // from before this edge, independent of statement order.
        if (rst) begin
            state_q    <= S_IDLE;
            thr_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            fsad_q     <= '0;
            res_sad_q  <= '0;
            res_mvec_q <= '0;
            res_x_q    <= '0;
            res_y_q    <= '0;
        end else begin
            state_q    <= state_d;
            thr_q      <= thr_d;
            x_q        <= x_d;
            y_q        <= y_d;
            fsad_q     <= fsad_d;
            res_sad_q  <= res_sad_d;
            res_mvec_q <= res_mvec_d;
            res_x_q    <= res_x_d;
            res_y_q    <= res_y_d;
        end
    end

`ifdef ME_FRAME_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            res_err_q  <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            res_err_q  <= res_err_d;
        end
    end

    assign res_err = res_err_q;
`else
    assign res_err = 1'b0;
`endif

    // -------------------------------------------------------------------------
    // Outputs: control strobes decode straight from the registered state, so
    // me_req falls on the same edge that captures the ack and PUSH always
    // separates two requests by at least one low cycle.
    // -------------------------------------------------------------------------
    assign busy         = (state_q == S_ISSUE) || (state_q == S_WAIT) || (state_q == S_PUSH);
    assign done         = (state_q == S_DONE);
    assign me_req       = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign res_valid    = (state_q == S_PUSH);
    assign me_threshold = thr_q;
    assign me_mb_x      = x_q;
    assign me_mb_y      = y_q;
    assign frame_sad    = fsad_q;
    assign res_sad      = res_sad_q;
    assign res_mvec     = res_mvec_q;
    assign res_mb_x     = res_x_q;
    assign res_mb_y     = res_y_q;

endmodule

// File: tb/tb_me_frame_sched.sv
// -----------------------------------------------------------------------------
// tb_me_frame_sched
//
// Directed bench for me_frame_sched with FSAD_WIDTH = SAD_WIDTH so the frame
// total can be driven into saturation. A behavioural core answers each request
// five cycles later with sad = 10*n and mvec = 0x100+n, pushing the expected
// result into a queue; the result stream is popped and compared on handshake.
// The watchdog scenario is included when ME_FRAME_SCHED_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_me_frame_sched;

    localparam int MB_COLS    = 4;
    localparam int MB_ROWS    = 3;
    localparam int SAD_WIDTH  = 16;
    localparam int CNT_WIDTH  = 12;
    localparam int FSAD_WIDTH = 16;
    localparam int TIMEOUT    = 16;
    localparam int N_MB       = MB_COLS * MB_ROWS;
    localparam int ACK_DELAY  = 5;

    logic                  clk;
    logic                  rst;
    logic                  start;
    logic [SAD_WIDTH-1:0]  threshold;
    logic                  busy;
    logic                  done;
    logic [FSAD_WIDTH-1:0] frame_sad;
    logic                  me_req;
    logic [SAD_WIDTH-1:0]  me_threshold;
    logic [1:0]            me_mb_x;
    logic [1:0]            me_mb_y;
    logic                  me_ack;
    logic [SAD_WIDTH-1:0]  me_sad;
    logic [CNT_WIDTH-1:0]  me_mvec;
    logic                  res_valid;
    logic                  res_ready;
    logic [SAD_WIDTH-1:0]  res_sad;
    logic [CNT_WIDTH-1:0]  res_mvec;
    logic [1:0]            res_mb_x;
    logic [1:0]            res_mb_y;
    logic                  res_err;

    me_frame_sched #(
        .MB_COLS   (MB_COLS),
        .MB_ROWS   (MB_ROWS),
        .SAD_WIDTH (SAD_WIDTH),
        .CNT_WIDTH (CNT_WIDTH),
        .FSAD_WIDTH(FSAD_WIDTH),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .threshold   (threshold),
        .busy        (busy),
        .done        (done),
        .frame_sad   (frame_sad),
        .me_req      (me_req),
        .me_threshold(me_threshold),
        .me_mb_x     (me_mb_x),
        .me_mb_y     (me_mb_y),
        .me_ack      (me_ack),
        .me_sad      (me_sad),
        .me_mvec     (me_mvec),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_sad     (res_sad),
        .res_mvec    (res_mvec),
        .res_mb_x    (res_mb_x),
        .res_mb_y    (res_mb_y),
        .res_err     (res_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [SAD_WIDTH-1:0] sad;
        logic [CNT_WIDTH-1:0] mvec;
        logic [1:0]           x;
        logic [1:0]           y;
        logic                 err;
    } res_t;

    res_t exp_q[$];

    int errors = 0;
    int checks = 0;

    // Core-model state (written only by the core process).
    int mb_n       = 0;
    int n_results  = 0;
    int done_cnt   = 0;
    int stray_done = 0;
    int tmo_done   = 0;
    // Requests from the directed sequence (written only by it).
    int stray_req  = 0;
    int tmo_req    = 0;
    bit core_en    = 1'b1;
    bit all_ff     = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Core model and result scoreboard, all sampled on the falling edge.
    // -------------------------------------------------------------------------
    initial begin : core_model
        int   wait_cnt;
        bit   pending;
        res_t e;
        wait_cnt = 0;
        pending  = 1'b0;
        me_ack   = 1'b0;
        me_sad   = '0;
        me_mvec  = '0;
        forever begin
            @(negedge clk);
            me_ack = 1'b0;
            if (rst) begin
                mb_n    = 0;
                pending = 1'b0;
                exp_q.delete();
            end else begin
                if (done) done_cnt++;
                if (res_valid && res_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("res_sad",  32'(res_sad),  32'(e.sad));
                        check("res_mvec", 32'(res_mvec), 32'(e.mvec));
                        check("res_mb_x", 32'(res_mb_x), 32'(e.x));
                        check("res_mb_y", 32'(res_mb_y), 32'(e.y));
                        check("res_err",  32'(res_err),  32'(e.err));
                    end
                    n_results++;
                end
                if (tmo_done != tmo_req) begin
                    // Timed-out MB 0: expected error result, core moves on to MB 1.
                    e = '{sad: 16'hFFFF, mvec: 12'h000, x: 2'd0, y: 2'd0, err: 1'b1};
                    exp_q.push_back(e);
                    mb_n = 1;
                    tmo_done++;
                end else if (stray_done != stray_req) begin
                    me_ack  = 1'b1;
                    me_sad  = 16'h1234;
                    me_mvec = 12'hABC;
                    stray_done++;
                end else if (pending) begin
                    wait_cnt++;
                    if (wait_cnt == ACK_DELAY) begin
                        me_ack  = 1'b1;
                        me_sad  = all_ff ? 16'hFFFF : 16'(10 * mb_n);
                        me_mvec = 12'(256 + mb_n);
                        e = '{sad: me_sad, mvec: me_mvec, x: 2'(mb_n % MB_COLS),
                              y: 2'(mb_n / MB_COLS), err: 1'b0};
                        exp_q.push_back(e);
                        mb_n    = (mb_n + 1) % N_MB;
                        pending = 1'b0;
                    end
                end else if (core_en && me_req) begin
                    pending  = 1'b1;
                    wait_cnt = 0;
                    check("req_mb_x", 32'(me_mb_x), 32'(mb_n % MB_COLS));
                    check("req_mb_y", 32'(me_mb_y), 32'(mb_n / MB_COLS));
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Directed-sequence helpers: inputs change 1 ns after the rising edge.
    // -------------------------------------------------------------------------
    task automatic start_frame(input logic [SAD_WIDTH-1:0] thr);
        @(posedge clk); #1;
        threshold = thr;
        start     = 1'b1;
        @(posedge clk); #1;
        start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_res(input string tag, input int mx, input int my, input int max_cycles);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            @(negedge clk);
            if (res_valid) seen = 1'b1;
        end
        check({tag, "_valid_seen"}, 32'(seen), 32'd1);
        check({tag, "_pos"}, {30'd0, res_mb_x} + 32'(res_mb_y) * 4, 32'(mx + my * 4));
    endtask

    task automatic pulse_ready();
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin : directed
        int d0;
        int r0;
        int req_cycles;
        bit seen;

        rst       = 1'b1;
        start     = 1'b0;
        threshold = '0;
        res_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_busy",      32'(busy),         32'd0);
        check("rst_done",      32'(done),         32'd0);
        check("rst_me_req",    32'(me_req),       32'd0);
        check("rst_res_valid", 32'(res_valid),    32'd0);
        check("rst_frame_sad", 32'(frame_sad),    32'd0);
        check("rst_me_thr",    32'(me_threshold), 32'd0);
        check("rst_mb_xy",     {28'd0, me_mb_x, me_mb_y}, 32'd0);
        check("rst_res_word",  {3'd0, res_sad, res_mvec} | 32'(res_mb_x) | 32'(res_mb_y) | 32'(res_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---- 1: full frame, core acks after 5 cycles, ready always high ----
        d0 = done_cnt;
        r0 = n_results;
        res_ready = 1'b1;
        start_frame(16'h0100);
        @(negedge clk);
        check("f1_busy",   32'(busy),         32'd1);
        check("f1_me_req", 32'(me_req),       32'd1);
        check("f1_me_thr", 32'(me_threshold), 32'h100);
        wait_done("f1", 400);
        check("f1_busy_at_done", 32'(busy),      32'd0);
        check("f1_frame_sad",    32'(frame_sad), 32'd660);
        @(negedge clk);
        check("f1_done_1cycle",  32'(done),          32'd0);
        check("f1_sad_held",     32'(frame_sad),     32'd660);
        check("f1_results",      32'(n_results - r0), 32'd12);
        check("f1_done_pulses",  32'(done_cnt - d0),  32'd1);
        check("f1_queue_empty",  32'(exp_q.size()),   32'd0);

        // ---- 2: backpressure on MB 1 ----------------------------------------
        d0 = done_cnt;
        r0 = n_results;
        res_ready = 1'b0;
        start_frame(16'h0055);
        wait_res("f2_mb0", 0, 0, 50);
        pulse_ready();
        wait_res("f2_mb1", 1, 0, 50);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("f2_hold_valid", 32'(res_valid), 32'd1);
            check("f2_hold_sad",   32'(res_sad),   32'd10);
            check("f2_hold_mvec",  32'(res_mvec),  32'h101);
            check("f2_hold_req",   32'(me_req),    32'd0);
        end
        pulse_ready();
        wait_res("f2_mb2", 2, 0, 50);
        pulse_ready();

        // ---- 3: start during WAIT of MB 3 is ignored -------------------------
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (me_req && me_mb_x == 2'd3 && me_mb_y == 2'd0) seen = 1'b1;
        end
        check("f3_mb3_req_seen", 32'(seen), 32'd1);
        start_frame(16'h0AAA);
        @(negedge clk);
        check("f3_thr_kept", 32'(me_threshold), 32'h055);
        check("f3_busy",     32'(busy),         32'd1);
        check("f3_mb_x",     32'(me_mb_x),      32'd3);
        @(posedge clk); #1;
        res_ready = 1'b1;
        wait_done("f2", 400);
        check("f2_frame_sad", 32'(frame_sad), 32'd660);
        @(negedge clk);
        check("f2_results",     32'(n_results - r0), 32'd12);
        check("f2_done_pulses", 32'(done_cnt - d0),  32'd1);
        // Stray ack while idle.
        r0 = n_results;
        stray_req++;
        repeat (4) @(negedge clk);
        check("f3_idle_valid",   32'(res_valid),       32'd0);
        check("f3_idle_busy",    32'(busy),            32'd0);
        check("f3_idle_req",     32'(me_req),          32'd0);
        check("f3_idle_fsad",    32'(frame_sad),       32'd660);
        check("f3_idle_results", 32'(n_results - r0),  32'd0);

        // ---- 4: saturating frame total ---------------------------------------
        all_ff = 1'b1;
        start_frame(16'h0200);
        wait_done("f4", 400);
        check("f4_frame_sad_sat", 32'(frame_sad), 32'hFFFF);
        @(posedge clk); #1;
        all_ff = 1'b0;

        // ---- 5: reset while MB 5 sits in PUSH --------------------------------
        res_ready = 1'b0;
        start_frame(16'h0300);
        for (int n = 0; n < 5; n++) begin
            wait_res("f5_pre", n % MB_COLS, n / MB_COLS, 50);
            pulse_ready();
        end
        wait_res("f5_mb5", 1, 1, 50);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("f5_busy",      32'(busy),      32'd0);
        check("f5_res_valid", 32'(res_valid), 32'd0);
        check("f5_me_req",    32'(me_req),    32'd0);
        check("f5_frame_sad", 32'(frame_sad), 32'd0);
        check("f5_mb_xy",     {28'd0, me_mb_x, me_mb_y}, 32'd0);
        r0 = n_results;
        res_ready = 1'b1;
        start_frame(16'h0100);
        wait_done("f5_restart", 400);
        check("f5_restart_fsad", 32'(frame_sad), 32'd660);
        @(negedge clk);
        check("f5_restart_results", 32'(n_results - r0), 32'd12);

`ifdef ME_FRAME_SCHED_TIMEOUT_EN
        // ---- 6: core never acks MB 0 -----------------------------------------
        @(posedge clk); #1;
        res_ready = 1'b0;
        core_en   = 1'b0;
        start_frame(16'h0100);
        req_cycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (me_req) req_cycles++;
        end
        check("f6_req_cycles", 32'(req_cycles), 32'(TIMEOUT + 1));
        check("f6_valid",      32'(res_valid),  32'd1);
        check("f6_sad",        32'(res_sad),    32'hFFFF);
        check("f6_mvec",       32'(res_mvec),   32'd0);
        check("f6_err",        32'(res_err),    32'd1);
        check("f6_fsad",       32'(frame_sad),  32'hFFFF);
        stray_req++;
        repeat (3) @(negedge clk);
        check("f6_late_ack_sad", 32'(res_sad),   32'hFFFF);
        check("f6_late_ack_err", 32'(res_err),   32'd1);
        check("f6_late_ack_vld", 32'(res_valid), 32'd1);
        tmo_req++;
        repeat (2) @(negedge clk);
        r0 = n_results;
        @(posedge clk); #1;
        core_en   = 1'b1;
        res_ready = 1'b1;
        wait_done("f6", 400);
        check("f6_final_fsad", 32'(frame_sad), 32'hFFFF);
        @(negedge clk);
        check("f6_results", 32'(n_results - r0), 32'd12);
`else
        req_cycles = 0;
`endif

        repeat (2) @(negedge clk);
        check("end_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
